// File: rtl/pingpong_buffer_nch_pkg.sv
// Shared types and defaults for the multi-channel ping-pong buffer.
// Also used by the FFT/IFFT integration wrappers.
package pingpong_buffer_nch_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  // Lane positions for the common two-lane I/Q packing.
  localparam int LANES_IQ = 2;
  localparam int LANE_I   = 0;
  localparam int LANE_Q   = 1;

  localparam int DATA_WIDTH_FFT  = 18;
  localparam int DATA_WIDTH_IFFT = 26;
  localparam int MEM_DEPTH_FFT   = 1200;
  localparam int MEM_DEPTH_IFFT  = 2048;

endpackage

// File: rtl/pingpong_buffer_nch_bank_ram.sv
// Simple dual-port RAM holding both banks back to back; all lanes share one word.
// Read data is registered and can be forced to zero for out-of-range reads.
module pingpong_bank_ram #(
  parameter int W     = 36,
  parameter int DEPTH = 1200,
  parameter int AW    = 11
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          wr_en_i,
  input  logic          wr_bank_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  input  logic          rd_clr_i,
  input  logic          rd_bank_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  localparam int IW = $clog2(2 * DEPTH);

  logic [W-1:0] mem [2*DEPTH];
  logic [W-1:0] rd_data_q;

  // Bank 1 sits directly above bank 0, so the array is exactly 2*DEPTH deep.
  function automatic logic [IW-1:0] lin_index(input logic bank, input logic [AW-1:0] addr);
    return IW'(addr) + (bank ? IW'(DEPTH) : IW'(0));
  endfunction

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[lin_index(wr_bank_i, wr_addr_i)] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || rd_clr_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[lin_index(rd_bank_i, rd_addr_i)];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pingpong_buffer_nch.sv
// Two-bank ping-pong buffer carrying NUM_CH lanes per address, with explicit
// bank ownership between a sample writer and a block reader.
module pingpong_buffer_nch
  import pingpong_buffer_nch_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_CH     = 2,
  parameter int MEM_DEPTH  = 1200,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
  input  logic                         wr_last,
  output logic                         wr_ready,
  output logic                         rd_avail,
  output logic [ADDR_WIDTH:0]          rd_len,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
  input  logic                         rd_release,
  output logic                         rd_bank,
  output logic                         err_overflow,
  output logic                         err_addr
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(MEM_DEPTH);

  bank_state_e   state_q [2];
  bank_state_e   state_d [2];
  logic [LW-1:0] len_q [2];
  logic [LW-1:0] len_d [2];
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic          rd_valid_q;
  logic          err_overflow_q, err_overflow_d;
  logic          err_addr_q, err_addr_d;

  logic wr_in_range, rd_in_range;
  logic wr_accept, wr_close;
  logic rd_fire, rd_rel_fire;

  // Handshake: the writer owns bank wb only while it is FILLING (wr_ready);
  // the reader owns bank rb while FULL/READING (rd_avail). A strobe without
  // ownership is dropped; rd_release hands the bank back to the writer.
  assign wr_ready    = (state_q[wb_q] == BANK_FILLING);
  assign rd_avail    = (state_q[rb_q] == BANK_FULL) || (state_q[rb_q] == BANK_READING);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_accept   = wr_en && wr_ready && wr_in_range;
  assign wr_close    = wr_en && wr_ready && wr_last;
  assign rd_fire     = rd_en && rd_avail;
  assign rd_rel_fire = rd_release && rd_avail;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    wb_d           = wb_q;
    rb_d           = rb_q;
    err_overflow_d = err_overflow_q | (wr_en & ~wr_ready);
    err_addr_d     = err_addr_q | (wr_en & ~wr_in_range) | (rd_fire & ~rd_in_range);

    // Release is resolved before the write close so the writer can claim the
    // freed bank on the same edge.
    if (rd_rel_fire) begin
      state_d[rb_q] = BANK_EMPTY;
      rb_d          = ~rb_q;
    end else if (rd_fire && (state_q[rb_q] == BANK_FULL)) begin
      state_d[rb_q] = BANK_READING;
    end

    if (wr_close) begin
      state_d[wb_q] = BANK_FULL;
      len_d[wb_q]   = wr_in_range ? ({1'b0, wr_addr} + LW'(1)) : DEPTH_L;
      wb_d          = ~wb_q;
    end

    // A writer stalled on an occupied bank resumes as soon as it is emptied.
    if (state_d[wb_d] == BANK_EMPTY) begin
      state_d[wb_d] = BANK_FILLING;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q[0]     <= BANK_FILLING;
      state_q[1]     <= BANK_EMPTY;
      len_q[0]       <= '0;
      len_q[1]       <= '0;
      wb_q           <= 1'b0;
      rb_q           <= 1'b0;
      rd_valid_q     <= 1'b0;
      err_overflow_q <= 1'b0;
      err_addr_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      wb_q           <= wb_d;
      rb_q           <= rb_d;
      rd_valid_q     <= rd_fire;
      err_overflow_q <= err_overflow_d;
      err_addr_q     <= err_addr_d;
    end
  end

  pingpong_bank_ram #(
    .W     (NUM_CH * DATA_WIDTH),
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (wr_accept),
    .wr_bank_i (wb_q),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_fire && rd_in_range),
    .rd_clr_i  (rd_fire && !rd_in_range),
    .rd_bank_i (rb_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign rd_len       = len_q[rb_q];
  assign rd_valid     = rd_valid_q;
  assign rd_bank      = rb_q;
  assign err_overflow = err_overflow_q;
  assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_pingpong_buffer_nch.sv
// Bench for pingpong_buffer_nch: a 2-lane 18-bit instance for bank control and
// a 4-lane 26-bit instance for lane independence.
module tb_pingpong_buffer_nch;

  localparam int DW  = 18;
  localparam int NCH = 2;
  localparam int DEP = 1200;
  localparam int AW  = 11;
  localparam int WA  = NCH * DW;

  localparam int DWB  = 26;
  localparam int NCHB = 4;
  localparam int DEPB = 16;
  localparam int AWB  = 5;
  localparam int WB   = NCHB * DWB;

  logic clk;
  logic reset;

  logic          a_wr_en, a_wr_last, a_wr_ready, a_rd_avail, a_rd_en, a_rd_valid;
  logic          a_rd_release, a_rd_bank, a_err_overflow, a_err_addr;
  logic [AW-1:0] a_wr_addr, a_rd_addr;
  logic [AW:0]   a_rd_len;
  logic [WA-1:0] a_wr_data, a_rd_data;

  logic           b_wr_en, b_wr_last, b_wr_ready, b_rd_avail, b_rd_en, b_rd_valid;
  logic           b_rd_release, b_rd_bank, b_err_overflow, b_err_addr;
  logic [AWB-1:0] b_wr_addr, b_rd_addr;
  logic [AWB:0]   b_rd_len;
  logic [WB-1:0]  b_wr_data, b_rd_data;

  logic [WA-1:0] exp_q[$];
  logic [WB-1:0] exp_b_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [DWB-1:0] pats_b [4];

  pingpong_buffer_nch #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MEM_DEPTH(DEP), .ADDR_WIDTH(AW)) dut_a (
    .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_last(a_wr_last), .wr_ready(a_wr_ready), .rd_avail(a_rd_avail), .rd_len(a_rd_len),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .rd_release(a_rd_release), .rd_bank(a_rd_bank), .err_overflow(a_err_overflow),
    .err_addr(a_err_addr)
  );

  pingpong_buffer_nch #(.DATA_WIDTH(DWB), .NUM_CH(NCHB), .MEM_DEPTH(DEPB), .ADDR_WIDTH(AWB)) dut_b (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_last(b_wr_last), .wr_ready(b_wr_ready), .rd_avail(b_rd_avail), .rd_len(b_rd_len),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .rd_release(b_rd_release), .rd_bank(b_rd_bank), .err_overflow(b_err_overflow),
    .err_addr(b_err_addr)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: pop one expected word per rd_valid cycle.
  always @(negedge clk) begin
    if (a_rd_valid) begin
      if (exp_q.size() == 0) check("a_unexpected_valid", 128'(a_rd_valid), 128'(0));
      else check("a_rd_data", 128'(a_rd_data), 128'(exp_q.pop_front()));
    end
    if (b_rd_valid) begin
      if (exp_b_q.size() == 0) check("b_unexpected_valid", 128'(b_rd_valid), 128'(0));
      else check("b_rd_data", 128'(b_rd_data), 128'(exp_b_q.pop_front()));
    end
  end

  function automatic logic [WA-1:0] pat_a(input int tag, input int addr);
    logic [DW-1:0] l0, l1;
    l0 = DW'(tag * 4096 + addr);
    l1 = -l0;
    return {l1, l0};
  endfunction

  function automatic logic [WB-1:0] pat_b(input int i);
    logic [WB-1:0] w;
    for (int k = 0; k < NCHB; k++) w[k*DWB +: DWB] = pats_b[(i + k) % 4];
    return w;
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int addr, input logic [WA-1:0] d, input logic last);
    a_wr_en = 1'b1; a_wr_addr = AW'(addr); a_wr_data = d; a_wr_last = last;
    step();
    a_wr_en = 1'b0; a_wr_last = 1'b0;
  endtask

  task automatic rd_a(input int addr, input logic [WA-1:0] exp, input logic rel);
    a_rd_en = 1'b1; a_rd_addr = AW'(addr); a_rd_release = rel;
    exp_q.push_back(exp);
    step();
    a_rd_en = 1'b0; a_rd_release = 1'b0;
  endtask

  task automatic release_a();
    a_rd_release = 1'b1;
    step();
    a_rd_release = 1'b0;
  endtask

  initial begin
    pats_b[0] = 26'h1; pats_b[1] = 26'h2AAAAAA; pats_b[2] = 26'h3FFFFFF; pats_b[3] = 26'h0;
    reset = 1'b1;
    a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0; a_wr_last = 0;
    a_rd_en = 0; a_rd_addr = '0; a_rd_release = 0;
    b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_wr_last = 0;
    b_rd_en = 0; b_rd_addr = '0; b_rd_release = 0;
    repeat (3) step();
    check("rst_wr_ready", 128'(a_wr_ready), 128'(1));
    check("rst_rd_avail", 128'(a_rd_avail), 128'(0));
    check("rst_rd_valid", 128'(a_rd_valid), 128'(0));
    check("rst_rd_data", 128'(a_rd_data), 128'(0));
    check("rst_rd_len", 128'(a_rd_len), 128'(0));
    check("rst_errors", 128'({a_err_overflow, a_err_addr}), 128'(0));
    reset = 1'b0;

    // Full 1200-entry frame, then read with lane-level checks
    for (int i = 0; i < DEP; i++) wr_a(i, pat_a(0, i), i == DEP - 1);
    check("t1_rd_avail", 128'(a_rd_avail), 128'(1));
    check("t1_rd_len", 128'(a_rd_len), 128'(1200));
    check("t1_wr_ready", 128'(a_wr_ready), 128'(1));
    rd_a(5, pat_a(0, 5), 1'b0);
    check("t1_valid", 128'(a_rd_valid), 128'(1));
    check("t1_lane0", 128'(a_rd_data[DW-1:0]), 128'(18'd5));
    check("t1_lane1", 128'(a_rd_data[2*DW-1:DW]), 128'(18'h3FFFB));
    rd_a(0, pat_a(0, 0), 1'b0);
    rd_a(DEP - 1, pat_a(0, DEP - 1), 1'b0);
    step();
    check("t1_valid_low", 128'(a_rd_valid), 128'(0));
    check("t1_data_hold", 128'(a_rd_data), 128'(pat_a(0, DEP - 1)));
    release_a();
    check("t1_rel_avail", 128'(a_rd_avail), 128'(0));
    check("t1_rel_bank", 128'(a_rd_bank), 128'(1));
    a_rd_en = 1'b1;
    step();
    a_rd_en = 1'b0;
    check("rd_no_avail_valid", 128'(a_rd_valid), 128'(0));

    // Both banks full, overflow, release
    for (int i = 0; i < 4; i++) wr_a(i, pat_a(1, i), i == 3);
    for (int i = 0; i < 4; i++) wr_a(i, pat_a(2, i), i == 3);
    check("t2_wr_ready_low", 128'(a_wr_ready), 128'(0));
    check("t2_no_overflow", 128'(a_err_overflow), 128'(0));
    wr_a(0, '1, 1'b1);
    check("t2_overflow", 128'(a_err_overflow), 128'(1));
    check("t2_still_blocked", 128'(a_wr_ready), 128'(0));
    check("t2_rd_len", 128'(a_rd_len), 128'(4));
    rd_a(3, pat_a(1, 3), 1'b0);
    release_a();
    check("t2_wr_ready", 128'(a_wr_ready), 128'(1));
    check("t2_rd_bank", 128'(a_rd_bank), 128'(0));
    check("t2_rd_len0", 128'(a_rd_len), 128'(4));
    for (int i = 0; i < 4; i++) rd_a(i, pat_a(2, i), 1'b0);

    // Close on bank1 together with release of bank0
    wr_a(0, pat_a(3, 0), 1'b0);
    wr_a(1, pat_a(3, 1), 1'b0);
    a_rd_release = 1'b1;
    wr_a(2, pat_a(3, 2), 1'b1);
    a_rd_release = 1'b0;
    check("t3_wr_ready", 128'(a_wr_ready), 128'(1));
    check("t3_rd_bank", 128'(a_rd_bank), 128'(1));
    check("t3_rd_avail", 128'(a_rd_avail), 128'(1));
    check("t3_rd_len", 128'(a_rd_len), 128'(3));
    rd_a(2, pat_a(3, 2), 1'b0);
    rd_a(1, pat_a(3, 1), 1'b1);
    check("t3_rel_avail", 128'(a_rd_avail), 128'(0));
    check("t3_rel_bank", 128'(a_rd_bank), 128'(0));

    // Out-of-range addresses
    wr_a(1300, '1, 1'b0);
    check("t4_err_addr", 128'(a_err_addr), 128'(1));
    check("t4_no_close", 128'(a_rd_avail), 128'(0));
    wr_a(0, pat_a(4, 0), 1'b0);
    wr_a(1, pat_a(4, 1), 1'b0);
    wr_a(1300, '1, 1'b1);
    check("t4_rd_avail", 128'(a_rd_avail), 128'(1));
    check("t4_rd_len", 128'(a_rd_len), 128'(1200));
    rd_a(1, pat_a(4, 1), 1'b0);
    rd_a(1250, '0, 1'b0);
    check("t4_oor_valid", 128'(a_rd_valid), 128'(1));
    check("t4_oor_data", 128'(a_rd_data), 128'(0));

    // Reset mid-frame
    for (int i = 0; i < 10; i++) wr_a(i, pat_a(5, i), 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_wr_ready", 128'(a_wr_ready), 128'(1));
    check("t5_rd_avail", 128'(a_rd_avail), 128'(0));
    check("t5_rd_bank", 128'(a_rd_bank), 128'(0));
    check("t5_errors", 128'({a_err_overflow, a_err_addr}), 128'(0));
    for (int i = 0; i < 3; i++) wr_a(i, pat_a(6, i), i == 2);
    check("t5_rd_len", 128'(a_rd_len), 128'(3));
    check("t5_rd_avail2", 128'(a_rd_avail), 128'(1));
    rd_a(2, pat_a(6, 2), 1'b0);
    wr_a(0, pat_a(7, 0), 1'b1);
    check("t5_single_block", 128'(a_wr_ready), 128'(0));
    release_a();
    check("t5_single_len", 128'(a_rd_len), 128'(1));
    check("t5_single_bank", 128'(a_rd_bank), 128'(1));
    rd_a(0, pat_a(7, 0), 1'b0);

    // Four independent 26-bit lanes
    for (int i = 0; i < 4; i++) begin
      b_wr_en = 1'b1; b_wr_addr = AWB'(i); b_wr_data = pat_b(i); b_wr_last = (i == 3);
      step();
    end
    b_wr_en = 1'b0; b_wr_last = 1'b0;
    check("b_rd_len", 128'(b_rd_len), 128'(4));
    for (int i = 0; i < 4; i++) begin
      b_rd_en = 1'b1; b_rd_addr = AWB'(i);
      exp_b_q.push_back(pat_b(i));
      step();
    end
    b_rd_en = 1'b0;
    check("b_lane3_last", 128'(b_rd_data[3*DWB +: DWB]), 128'(26'h3FFFFFF));

    repeat (3) step();
    check("a_queue_drained", 128'(exp_q.size()), 128'(0));
    check("b_queue_drained", 128'(exp_b_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
